// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//
// Drives the multi-cycle CPU instruction sequence. A one-hot phase ring
// (fetch, decode, execute, memory, writeback) advances one step per cycle.
// The sequencer owns the program counter and the instruction register. The
// instruction register is loaded from the main memory read data at the end
// of decode and is split into op1/op2/op3/imm fields for downstream stages.
//
// Ports:
//   clk            in   1   clock
//   rst            in   1   synchronous active-low reset
//   stall          in   1   hold all sequencer state this cycle
//   mem_rdata      in  32   memory read data (the instruction during decode)
//   branch_taken   in   1   take branch_target at the end of writeback
//   branch_target  in  32   next PC when the branch is taken
//   phase          out  5   one-hot phase f/d/e/m/w; all-zero once halted
//   pc             out 32   current program counter (word address)
//   op1            out  8   ir[31:24]
//   op2            out  2   ir[23:22]
//   op3            out  3   ir[21:19]
//   imm            out 32   ir[15:0] sign-extended
//   halted         out  1   sequencer has stopped on HALT_OP
//   retired        out 32   count of completed instructions (wraps)
//
// Handshake: there is no valid/ready pair here. stall is a plain qualifier:
// while it is high every register holds. Once halted, only reset has an effect.

module fetch_sequencer #(
    parameter int unsigned ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [7:0]  HALT_OP  = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] mem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [4:0]  phase,
    output logic [31:0] pc,
    output logic [7:0]  op1,
    output logic [1:0]  op2,
    output logic [2:0]  op3,
    output logic [31:0] imm,
    output logic        halted,
    output logic [31:0] retired
);

    // The state encodings are the phase outputs themselves. PH_HALT (all-zero)
    // is entered only from writeback of a HALT_OP instruction.
    typedef enum logic [4:0] {
        PH_HALT = 5'b00000,
        PH_F    = 5'b00001,
        PH_D    = 5'b00010,
        PH_E    = 5'b00100,
        PH_M    = 5'b01000,
        PH_W    = 5'b10000
    } phase_e;

    // Only the low ADDR_W bits of the PC are significant.
    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFF >> (32 - ADDR_W);

    phase_e      phase_q, phase_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        halted_q, halted_d;
    logic [31:0] retired_q, retired_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q   <= PH_F;
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0;
            halted_q  <= 1'b0;
            retired_q <= 32'h0;
        end else begin
            phase_q   <= phase_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        phase_d   = phase_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        halted_d  = halted_q;
        retired_d = retired_q;

        if (!halted_q && !stall) begin
            case (phase_q)
                PH_F: phase_d = PH_D;
                PH_D: begin
                    // Memory registered the word at the end of fetch.
                    ir_d    = mem_rdata;
                    phase_d = PH_E;
                end
                PH_E: phase_d = PH_M;
                PH_M: phase_d = PH_W;
                PH_W: begin
                    retired_d = retired_q + 32'd1;
                    if (branch_taken) begin
                        pc_d = branch_target & PC_MASK;
                    end else begin
                        pc_d = (pc_q + 32'd1) & PC_MASK;
                    end
                    if (ir_q[31:24] == HALT_OP) begin
                        phase_d  = PH_HALT;
                        halted_d = 1'b1;
                    end else begin
                        phase_d  = PH_F;
                    end
                end
                default: phase_d = phase_q;
            endcase
        end
    end

    assign phase   = phase_q;
    assign pc      = pc_q;
    assign op1     = ir_q[31:24];
    assign op2     = ir_q[23:22];
    assign op3     = ir_q[21:19];
    assign imm     = {{16{ir_q[15]}}, ir_q[15:0]};
    assign halted  = halted_q;
    assign retired = retired_q;

    // ir[18:16] carries no field for this stage.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir_q[18:16];

endmodule
